egg_timer_sequencer: RTL and testbench

Control FSM for the egg-timer countdown. It sits between the debounced front-panel buttons and the BCD countdown counter / seven-segment display driver. It selects the start time (switches or a soft/firm preset), issues the counter's load/start/enable controls, handles pause and abort, and runs a timed, blinking alarm phase after the counter reports done.

---
 rtl/egg_timer_sequencer.sv | 128 ++++++++++++
 tb/tb_egg_timer_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_sequencer.sv
// Egg-timer control FSM: selects the start time, drives counter load/start/enable,
// handles pause/abort and runs a timed, blinking alarm phase after the counter is done.
module egg_timer_sequencer #(
  parameter int unsigned ALARM_SECS = 10,
  parameter logic [15:0] SOFT_TIME  = 16'h0400,
  parameter logic [15:0] FIRM_TIME  = 16'h0700
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_preset,
  input  logic        firm,
  input  logic [15:0] sw_time,
  input  logic        done,
  output logic        load,
  output logic        str,
  output logic        enable,
  output logic [15:0] time_out,
  output logic        alarm,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam logic [8:0] ALARM_LAST = 9'(ALARM_SECS);

  state_t      cur_state, nxt_state;
  logic        start_prev, stop_prev, preset_prev;
  logic        start_edge, stop_edge, preset_edge;
  logic        use_preset, use_preset_nxt;
  logic [7:0]  tick_cnt, tick_cnt_nxt;
  logic [15:0] cand_time, time_nxt;
  logic        load_nxt, str_nxt, enable_nxt, alarm_nxt;

  // BCD mm:ss is startable only if every digit is decimal, seconds < 60 and nonzero.
  function automatic logic time_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) && (t != 16'h0000);
  endfunction

  assign start_edge  = btn_start  & ~start_prev;
  assign stop_edge   = btn_stop   & ~stop_prev;
  assign preset_edge = btn_preset & ~preset_prev;
  assign cand_time   = use_preset ? (firm ? FIRM_TIME : SOFT_TIME) : sw_time;
  assign state       = cur_state;

  always_comb begin
    nxt_state      = IDLE;
    use_preset_nxt = use_preset;
    tick_cnt_nxt   = tick_cnt;
    time_nxt       = time_out;
    case (cur_state)
      IDLE: begin
        time_nxt = cand_time;
        if (preset_edge) use_preset_nxt = ~use_preset;
        // Validation sees the pre-toggle candidate, the same value latched into time_out.
        nxt_state = (start_edge && time_valid(cand_time)) ? LOAD : IDLE;
      end
      LOAD:  nxt_state = RUN;
      RUN: begin
        if (done)           nxt_state = ALARM;
        else if (stop_edge) nxt_state = PAUSE;
        else                nxt_state = RUN;
      end
      PAUSE: begin
        if (stop_edge)       nxt_state = IDLE;
        else if (start_edge) nxt_state = RUN;
        else                 nxt_state = PAUSE;
      end
      ALARM: begin
        if (start_edge || stop_edge)                          nxt_state = IDLE;
        else if (tick && ({1'b0, tick_cnt} + 9'd1 == ALARM_LAST)) nxt_state = IDLE;
        else                                                  nxt_state = ALARM;
      end
      default: nxt_state = IDLE;
    endcase

    if (nxt_state == ALARM && cur_state != ALARM) tick_cnt_nxt = 8'd0;
    else if (cur_state == ALARM && tick)          tick_cnt_nxt = tick_cnt + 8'd1;

    load_nxt   = (nxt_state == LOAD);
    str_nxt    = (nxt_state != IDLE);
    enable_nxt = (nxt_state == RUN);
    alarm_nxt  = 1'b0;
    if (nxt_state == ALARM) begin
      if (cur_state != ALARM) alarm_nxt = 1'b1;
      else if (tick)          alarm_nxt = ~alarm;
      else                    alarm_nxt = alarm;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state   <= IDLE;
      start_prev  <= 1'b1;
      stop_prev   <= 1'b1;
      preset_prev <= 1'b1;
      use_preset  <= 1'b0;
      tick_cnt    <= 8'd0;
      time_out    <= 16'h0000;
      load        <= 1'b0;
      str         <= 1'b0;
      enable      <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      start_prev  <= btn_start;
      stop_prev   <= btn_stop;
      preset_prev <= btn_preset;
      use_preset  <= use_preset_nxt;
      tick_cnt    <= tick_cnt_nxt;
      time_out    <= time_nxt;
      load        <= load_nxt;
      str         <= str_nxt;
      enable      <= enable_nxt;
      alarm       <= alarm_nxt;
    end
  end

endmodule

// File: tb/tb_egg_timer_sequencer.sv
// Directed bench for egg_timer_sequencer with a per-cycle expectation scoreboard.
module tb_egg_timer_sequencer;

  logic        clk, reset, tick, btn_start, btn_stop, btn_preset, firm, done;
  logic [15:0] sw_time;
  logic        load, str, enable, alarm;
  logic [15:0] time_out;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        ld, s, en, al;
    logic [15:0] t;
  } exp_t;

  exp_t sb[$];

  egg_timer_sequencer #(.ALARM_SECS(4), .SOFT_TIME(16'h0400), .FIRM_TIME(16'h0700)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_preset(btn_preset), .firm(firm), .sw_time(sw_time), .done(done),
    .load(load), .str(str), .enable(enable), .time_out(time_out), .alarm(alarm),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge outputs, advance one clock, then pop and compare.
  task automatic step(input string tag, input logic [2:0] st, input logic ld, input logic s,
                      input logic en, input logic al, input logic [15:0] t);
    exp_t e;
    e.tag = tag; e.st = st; e.ld = ld; e.s = s; e.en = en; e.al = al; e.t = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"},  16'(state),  16'(e.st));
      chk({e.tag, ".load"},   16'(load),   16'(e.ld));
      chk({e.tag, ".str"},    16'(str),    16'(e.s));
      chk({e.tag, ".enable"}, 16'(enable), 16'(e.en));
      chk({e.tag, ".alarm"},  16'(alarm),  16'(e.al));
      chk({e.tag, ".time"},   time_out,    e.t);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_preset = 1'b0;
    firm = 1'b0; done = 1'b0; sw_time = 16'h0130;
    #1;

    // Reset, with start held through release
    step("rst0", 3'd0, 0, 0, 0, 0, 16'h0000);
    btn_start = 1'b1;
    step("rst1", 3'd0, 0, 0, 0, 0, 16'h0000);
    reset = 1'b1;
    step("rel_hold0", 3'd0, 0, 0, 0, 0, 16'h0130);
    step("rel_hold1", 3'd0, 0, 0, 0, 0, 16'h0130);
    btn_start = 1'b0;
    step("idle0", 3'd0, 0, 0, 0, 0, 16'h0130);

    // Load / run; time_out frozen once running
    btn_start = 1'b1;
    step("load", 3'd1, 1, 1, 0, 0, 16'h0130);
    btn_start = 1'b0;
    step("run0", 3'd2, 0, 1, 1, 0, 16'h0130);
    sw_time = 16'h0200;
    step("run_frozen", 3'd2, 0, 1, 1, 0, 16'h0130);

    // Pause / resume
    btn_stop = 1'b1;
    step("pause", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_stop = 1'b0;
    step("pause_hold", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_start = 1'b1;
    step("resume", 3'd2, 0, 1, 1, 0, 16'h0130);
    btn_start = 1'b1;
    step("run_start_ign", 3'd2, 0, 1, 1, 0, 16'h0130);
    btn_start = 1'b0;

    // Stop, stop again -> abort to IDLE
    btn_stop = 1'b1;
    step("pause2", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_stop = 1'b0;
    step("pause2_hold", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_stop = 1'b1;
    step("abort", 3'd0, 0, 0, 0, 0, 16'h0130);
    btn_stop = 1'b0;
    step("abort_idle", 3'd0, 0, 0, 0, 0, 16'h0200);

    // Reset mid-RUN for 3 cycles, start held through release
    btn_start = 1'b1;
    step("load2", 3'd1, 1, 1, 0, 0, 16'h0200);
    btn_start = 1'b0;
    step("run2", 3'd2, 0, 1, 1, 0, 16'h0200);
    reset = 1'b0;
    step("mid_rst0", 3'd0, 0, 0, 0, 0, 16'h0000);
    btn_start = 1'b1;
    step("mid_rst1", 3'd0, 0, 0, 0, 0, 16'h0000);
    step("mid_rst2", 3'd0, 0, 0, 0, 0, 16'h0000);
    reset = 1'b1;
    step("mid_rel", 3'd0, 0, 0, 0, 0, 16'h0200);
    btn_start = 1'b0;
    step("mid_idle", 3'd0, 0, 0, 0, 0, 16'h0200);

    // Invalid times: start is ignored
    sw_time = 16'h0075;
    step("inv75_sel", 3'd0, 0, 0, 0, 0, 16'h0075);
    btn_start = 1'b1;
    step("inv75_start", 3'd0, 0, 0, 0, 0, 16'h0075);
    btn_start = 1'b0;
    sw_time = 16'h0000;
    step("inv00_sel", 3'd0, 0, 0, 0, 0, 16'h0000);
    btn_start = 1'b1;
    step("inv00_start", 3'd0, 0, 0, 0, 0, 16'h0000);
    btn_start = 1'b0;
    sw_time = 16'h0A00;
    step("invA0_sel", 3'd0, 0, 0, 0, 0, 16'h0A00);
    btn_start = 1'b1;
    step("invA0_start", 3'd0, 0, 0, 0, 0, 16'h0A00);
    btn_start = 1'b0;

    // Start and stop together in PAUSE -> IDLE
    sw_time = 16'h0130;
    step("both_sel", 3'd0, 0, 0, 0, 0, 16'h0130);
    btn_start = 1'b1;
    step("both_load", 3'd1, 1, 1, 0, 0, 16'h0130);
    btn_start = 1'b0;
    step("both_run", 3'd2, 0, 1, 1, 0, 16'h0130);
    btn_stop = 1'b1;
    step("both_pause", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_stop = 1'b0;
    step("both_hold", 3'd3, 0, 1, 0, 0, 16'h0130);
    btn_start = 1'b1; btn_stop = 1'b1;
    step("both_abort", 3'd0, 0, 0, 0, 0, 16'h0130);
    btn_start = 1'b0; btn_stop = 1'b0;
    step("both_idle", 3'd0, 0, 0, 0, 0, 16'h0130);

    // Preset select
    firm = 1'b1; btn_preset = 1'b1;
    step("preset_edge", 3'd0, 0, 0, 0, 0, 16'h0130);
    btn_preset = 1'b0;
    step("preset_firm", 3'd0, 0, 0, 0, 0, 16'h0700);
    firm = 1'b0;
    step("preset_soft", 3'd0, 0, 0, 0, 0, 16'h0400);
    btn_start = 1'b1;
    step("preset_load", 3'd1, 1, 1, 0, 0, 16'h0400);
    btn_start = 1'b0;
    step("preset_run", 3'd2, 0, 1, 1, 0, 16'h0400);

    // Alarm, full duration of 4 ticks
    done = 1'b1;
    step("alm_entry", 3'd4, 0, 1, 0, 1, 16'h0400);
    done = 1'b0;
    step("alm_hold", 3'd4, 0, 1, 0, 1, 16'h0400);
    tick = 1'b1;
    step("alm_t1", 3'd4, 0, 1, 0, 0, 16'h0400);
    tick = 1'b0;
    step("alm_t1h", 3'd4, 0, 1, 0, 0, 16'h0400);
    tick = 1'b1;
    step("alm_t2", 3'd4, 0, 1, 0, 1, 16'h0400);
    tick = 1'b0;
    step("alm_t2h", 3'd4, 0, 1, 0, 1, 16'h0400);
    tick = 1'b1;
    step("alm_t3", 3'd4, 0, 1, 0, 0, 16'h0400);
    tick = 1'b0;
    step("alm_t3h", 3'd4, 0, 1, 0, 0, 16'h0400);
    tick = 1'b1;
    step("alm_t4_end", 3'd0, 0, 0, 0, 0, 16'h0400);
    tick = 1'b0;
    step("alm_idle", 3'd0, 0, 0, 0, 0, 16'h0400);

    // Alarm silenced by stop on the 2nd tick
    btn_start = 1'b1;
    step("sil_load", 3'd1, 1, 1, 0, 0, 16'h0400);
    btn_start = 1'b0;
    step("sil_run", 3'd2, 0, 1, 1, 0, 16'h0400);
    done = 1'b1;
    step("sil_entry", 3'd4, 0, 1, 0, 1, 16'h0400);
    done = 1'b0; tick = 1'b1;
    step("sil_t1", 3'd4, 0, 1, 0, 0, 16'h0400);
    tick = 1'b1; btn_stop = 1'b1;
    step("sil_t2_stop", 3'd0, 0, 0, 0, 0, 16'h0400);
    tick = 1'b0; btn_stop = 1'b0;
    step("sil_idle", 3'd0, 0, 0, 0, 0, 16'h0400);

    // done and stop together in RUN -> ALARM; start then exits
    btn_start = 1'b1;
    step("pri_load", 3'd1, 1, 1, 0, 0, 16'h0400);
    btn_start = 1'b0;
    step("pri_run", 3'd2, 0, 1, 1, 0, 16'h0400);
    done = 1'b1; btn_stop = 1'b1;
    step("pri_alarm", 3'd4, 0, 1, 0, 1, 16'h0400);
    done = 1'b0; btn_stop = 1'b0;
    step("pri_hold", 3'd4, 0, 1, 0, 1, 16'h0400);
    btn_start = 1'b1;
    step("pri_exit", 3'd0, 0, 0, 0, 0, 16'h0400);
    btn_start = 1'b0;
    step("pri_idle", 3'd0, 0, 0, 0, 0, 16'h0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
